// File: rtl/fpu_pipe_pkg.sv
// Shared FPU pipeline constants: per-operation latencies and default tag width.
package fpu_pipe_pkg;

    localparam int FPU_LAT_ADD = 4;
    localparam int FPU_LAT_MUL = 5;
    localparam int FPU_LAT_DIV = 12;
    localparam int FPU_LAT_MAX = 23;
    localparam int FPU_TAG_W   = 32;

    // Width needed to hold any latency / occupancy value 0..depth.
    function automatic int fpu_lat_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fpu_delay_stage.sv
// One {valid, data} stage of the delay line. Flush clears only the valid bit.
module fpu_delay_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv_i,
    input  logic             flush_i,
    input  logic             v_i,
    input  logic [WIDTH-1:0] d_i,
    output logic             v_o,
    output logic [WIDTH-1:0] d_o
);

    logic             v_q;
    logic [WIDTH-1:0] d_q;

    // Capture upstream on advance; flush drops validity but leaves data alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else if (flush_i) begin
            v_q <= 1'b0;
        end else if (adv_i) begin
            v_q <= v_i;
            d_q <= d_i;
        end
    end

    assign v_o = v_q;
    assign d_o = d_q;

endmodule

// File: rtl/fpu_delay_pipe.sv
// Stallable, flushable valid+data delay line with a runtime-selected output tap,
// occupancy tracking and a sticky latency-misuse flag.
module fpu_delay_pipe
    import fpu_pipe_pkg::*;
#(
    parameter int  WIDTH = FPU_TAG_W,
    parameter int  DEPTH = FPU_LAT_MAX,
    localparam int LW    = fpu_lat_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             stall,
    input  logic             flush,
    input  logic [LW-1:0]    lat_sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [LW-1:0]    occupancy,
    output logic             idle,
    output logic             lat_err
);

    logic             adv;
    logic             v_in [DEPTH];
    logic [WIDTH-1:0] d_in [DEPTH];
    logic             v_q  [DEPTH];
    logic [WIDTH-1:0] d_q  [DEPTH];

    logic             lat_legal;
    logic [LW-1:0]    tap;
    logic             tap_v;
    logic [WIDTH-1:0] tap_d;

    logic [LW-1:0]    occ_q, occ_d;
    logic [LW-1:0]    lat_sel_q;
    logic             err_q, err_d;

    assign adv = !stall && !flush;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign v_in[k] = in_valid;
            assign d_in[k] = in_data;
        end else begin : g_link
            assign v_in[k] = v_q[k-1];
            assign d_in[k] = d_q[k-1];
        end

        fpu_delay_stage #(.WIDTH(WIDTH)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .adv_i   (adv),
            .flush_i (flush),
            .v_i     (v_in[k]),
            .d_i     (d_in[k]),
            .v_o     (v_q[k]),
            .d_o     (d_q[k])
        );
    end

    // Out-of-range latency falls back to the deepest tap.
    assign lat_legal = (lat_sel != '0) && (lat_sel <= LW'(DEPTH));
    assign tap       = lat_legal ? lat_sel : LW'(DEPTH);

    // Tap mux straight off the stage registers, so no extra latency.
    always_comb begin
        tap_v = 1'b0;
        tap_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (tap == LW'(k + 1)) begin
                tap_v = v_q[k];
                tap_d = d_q[k];
            end
        end
    end

    // Occupancy and sticky error next-state; flush wins over everything.
    always_comb begin
        occ_d = occ_q;
        err_d = err_q;
        if (flush) begin
            occ_d = '0;
            err_d = 1'b0;
        end else begin
            if (!stall)
                occ_d = occ_q + LW'(in_valid) - LW'(tap_v);
            if (!lat_legal || ((lat_sel != lat_sel_q) && (occ_q != '0)))
                err_d = 1'b1;
        end
    end

    // Control registers; lat_sel is sampled every cycle regardless of stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q     <= '0;
            err_q     <= 1'b0;
            lat_sel_q <= LW'(DEPTH);
        end else begin
            occ_q     <= occ_d;
            err_q     <= err_d;
            lat_sel_q <= lat_sel;
        end
    end

    assign out_valid = tap_v;
    assign out_data  = tap_d;
    assign occupancy = occ_q;
    assign idle      = (occ_q == '0);
    assign lat_err   = err_q;

endmodule

// File: doc/fpu_delay_pipe.md
# fpu_delay_pipe

Parametrised, stallable, flushable delay line carrying a valid bit alongside WIDTH-bit data (operand tags, result metadata) so side-band information arrives in step with FPU datapath results. Output is taken from a runtime-selected tap, so one instance serves units of different latencies. An occupancy counter and sticky error flag support pipeline control and debug. Sits beside each FPU core's execution pipeline; the fixed 23-stage 32-bit delay line is the special case WIDTH=32, DEPTH=23, lat_sel=23, stall=0.

## Interface
- WIDTH, 32, data bits per stage
- DEPTH, 23, number of register stages (≥1); maximum selectable latency
- LW, $clog2(DEPTH+1), width of lat_sel and occupancy (derived localparam, not overridable)
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  input entry valid
- in_data  input  WIDTH  input entry data
- stall  input  1  hold all stages (no advance)
- flush  input  1  synchronous clear of all valid bits
- lat_sel  input  LW  output tap / latency, legal 1..DEPTH
- out_valid  output  1  valid bit of selected tap
- out_data  output  WIDTH  data of selected tap
- occupancy  output  LW  valid entries in stages 1..tap
- idle  output  1  occupancy == 0
- lat_err  output  1  sticky illegal-latency / unsafe-change flag

## Operation
- Stages s[1..DEPTH], each {v, d}. Advance = !stall & !flush.
- Advance: s[1] <= {in_valid, in_data}; s[k] <= s[k-1] for k=2..DEPTH. Stages beyond tap keep shifting, ignored.
- stall=1 (flush=0): every stage, occupancy and out_* hold; in_* is dropped (upstream must hold its entry).
- flush=1: all v <= 0, occupancy <= 0, lat_err <= 0; data regs hold; priority over stall and in_valid.
- Tap: tap = lat_sel if 1 ≤ lat_sel ≤ DEPTH, else DEPTH. out_valid = s[tap].v, out_data = s[tap].d (register outputs through mux, no added latency).
- Occupancy on advance: occupancy + in_valid − s[tap].v; never wraps (range 0..DEPTH by construction).
- lat_sel_q registered every cycle (reset to DEPTH). lat_err set when lat_sel illegal, or lat_sel != lat_sel_q while occupancy != 0. Cleared only by rst or flush (flush wins on same cycle).
- After an unsafe change, out_* and occupancy are not guaranteed consistent; recovery is flush.

## Timing
- Reset values: all v = 0, all d = 0, out_valid = 0, out_data = 0, occupancy = 0, idle = 1, lat_err = 0, lat_sel_q = DEPTH.
- Latency: entry accepted at edge t (advance) appears on out_* after exactly lat_sel advancing edges; stalled cycles add 1 each.
- Throughput 1 entry/cycle while no stall; bubbles (in_valid=0) are preserved in position.
- Simultaneous in and out on advance: occupancy unchanged.
- lat_sel change while idle=1: takes effect combinationally same cycle, no error.
- rst asserted mid-stream: all state cleared immediately, in-flight entries lost, no out_valid pulse.
- flush and stall same cycle: flush applies.

## Structure
- Shared package fpu_pipe_pkg: latency constants per FPU op (FPU_LAT_ADD, FPU_LAT_MUL, FPU_LAT_DIV, FPU_LAT_MAX=23) and default tag width; instances pass these to DEPTH/lat_sel.
- One sub-module: fpu_delay_stage (single {v, d} register with advance and flush inputs, async rst), generated DEPTH times; tap mux, occupancy counter, lat_sel_q and lat_err in the top.

## Test plan
- Reset/baseline: WIDTH=32, DEPTH=23, lat_sel=23, in_data=0xDEADBEEF valid at cycle 0, no stall -> out_valid=1, out_data=0xDEADBEEF at cycle 23 only; all outputs zero and idle=1 after rst.
- Tap select: lat_sel=4, stream 0x1,0x2,bubble,0x3 -> outputs 0x1,0x2,bubble,0x3 at cycles 4..7; occupancy peaks at 3, returns to 0, idle=1.
- Stall: lat_sel=5, entry 0xA5 at cycle 0, stall=1 for cycles 2–4 -> out_valid at cycle 8, occupancy held at 1 during stall, out_* unchanged during stall.
- Flush: 6 entries in flight (lat_sel=10), flush for one cycle with in_valid=1 and stall=1 -> next cycle occupancy=0, idle=1, no out_valid ever; lat_err cleared.
- Latency error: occupancy=2, change lat_sel 8->12 -> lat_err=1 next cycle, stays 1 until flush; lat_sel=0 while idle -> lat_err=1, tap=23.
- Async reset mid-stream: rst pulsed between clock edges with 5 entries in flight -> outputs clear without a clock edge, no later out_valid.
